pipe_hazard_ctrl: RTL and testbench

- Hazard and pipeline-sequencing controller for the 5-stage MIPS pipeline.
- Drives stall and flush (clear) of the F/D, D/E, E/M and M/W pipeline registers.
- Drives the forwarding muxes in the D and E stages.
- Sequences variable-latency data-memory accesses with a wait-state FSM and a timeout watchdog.

---
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: forwarding, stall/flush, mem wait FSM.
// Ports: clk, reset (async, active-high), stage register ids, write/load flags, BranchD, PCSrcD,
//   dmem_req/dmem_ready in; Stall*, Flush*, Forward*, mem_err, stall_count out.
// Optional: define HAZARD_STALL_CNT_EN to enable the 32-bit stall_count counter (else tied to 0).
module pipe_hazard_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  RsD,
   input  logic [4:0]  RtD,
   input  logic [4:0]  RsE,
   input  logic [4:0]  RtE,
   input  logic [4:0]  WriteRegE,
   input  logic [4:0]  WriteRegM,
   input  logic [4:0]  WriteRegW,
   input  logic        RegWriteE,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        MemtoRegE,
   input  logic        MemtoRegM,
   input  logic        BranchD,
   input  logic        PCSrcD,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushW,
   output logic        ForwardAD,
   output logic        ForwardBD,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        mem_err,
   output logic [31:0] stall_count
);

   typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] wait_cnt, cnt_nx;
   logic             lwstall, branchstall, memstall, stall_fd;

   // $0 is hardwired to zero, so it never creates a dependency.
   function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

   function automatic logic [1:0] fwd_e(input logic [4:0] src);
      if (RegWriteM && hit(src, WriteRegM))      return 2'b10;
      else if (RegWriteW && hit(src, WriteRegW)) return 2'b01;
      else                                       return 2'b00;
   endfunction

   assign lwstall = MemtoRegE && (hit(RsD, RtE) || hit(RtD, RtE));

   assign branchstall = BranchD &&
      ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
       (MemtoRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= cnt_nx;
      end
   end

   // Next-state logic; a request dropped mid-wait is ignored until ready.
   always_comb begin
      state_nx = state;
      cnt_nx   = wait_cnt;
      unique case (state)
         RUN: begin
            if (dmem_req && !dmem_ready) begin
               state_nx = WAIT;
               cnt_nx   = CNT_W'(1);
            end
         end
         WAIT: begin
            if (dmem_ready) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
               state_nx = ERR;
            end else begin
               cnt_nx = wait_cnt + CNT_W'(1);
            end
         end
         ERR:     state_nx = ERR;
         default: state_nx = RUN;
      endcase
   end

   // Outputs; everything is forced to its reset value while reset is held.
   always_comb begin
      memstall  = 1'b0;
      stall_fd  = 1'b0;
      mem_err   = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b1;
      FlushW    = 1'b0;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!reset) begin
         unique case (state)
            RUN:     memstall = dmem_req & ~dmem_ready;
            WAIT:    memstall = ~dmem_ready;
            ERR:     memstall = 1'b1;
            default: memstall = 1'b0;
         endcase
         mem_err   = (state == ERR);
         stall_fd  = lwstall | branchstall | memstall;
         StallF    = stall_fd;
         StallD    = stall_fd;
         StallE    = memstall;
         StallM    = memstall;
         // A frozen D/E register must keep its contents.
         FlushE    = (lwstall | branchstall) & ~memstall;
         // Bubble into W so a held M instruction writes back once.
         FlushW    = memstall;
         FlushD    = PCSrcD & ~stall_fd;
         ForwardAD = RegWriteM && hit(RsD, WriteRegM);
         ForwardBD = RegWriteM && hit(RtD, WriteRegM);
         ForwardAE = fwd_e(RsE);
         ForwardBE = fwd_e(RtE);
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       cnt_q <= '0;
      else if (StallF) cnt_q <= cnt_q + 32'd1;
   end

   assign stall_count = cnt_q;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random stimulus
// compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;
   localparam int MAX_WAIT = 15;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
   logic BranchD, PCSrcD, dmem_req, dmem_ready;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic ForwardAD, ForwardBD, mem_err;
   logic [1:0] ForwardAE, ForwardBE;
   logic [31:0] stall_count;

   pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .PCSrcD(PCSrcD),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mem_err(mem_err), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: an access in flight, how many cycles it has stalled, sticky error.
   bit          m_pend, m_err;
   int          m_waits;
   int unsigned m_cnt;

   logic e_sf, e_se, e_fd, e_fe, e_fw, e_fad, e_fbd, e_err;
   logic [1:0] e_fae, e_fbe;

   function automatic bit hit(logic [4:0] s, logic [4:0] d);
      return s != 5'd0 && s == d;
   endfunction

   function automatic logic [1:0] fwd(logic [4:0] s);
      if (RegWriteM && hit(s, WriteRegM)) return 2'd2;
      if (RegWriteW && hit(s, WriteRegW)) return 2'd1;
      return 2'd0;
   endfunction

   task automatic model_eval();
      bit lw, br, ms;
      if (reset) begin
         m_pend = 0; m_err = 0; m_waits = 0; m_cnt = 0;
         e_sf = 0; e_se = 0; e_fd = 0; e_fe = 1; e_fw = 0;
         e_fad = 0; e_fbd = 0; e_fae = 0; e_fbe = 0; e_err = 0;
      end else begin
         lw = MemtoRegE && (hit(RsD, RtE) || hit(RtD, RtE));
         br = BranchD &&
              ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
               (MemtoRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
         ms = m_err || ((m_pend || dmem_req) && !dmem_ready);
         e_sf  = lw || br || ms;
         e_se  = ms;
         e_fe  = (lw || br) && !ms;
         e_fw  = ms;
         e_fd  = PCSrcD && !e_sf;
         e_fad = RegWriteM && hit(RsD, WriteRegM);
         e_fbd = RegWriteM && hit(RtD, WriteRegM);
         e_fae = fwd(RsE);
         e_fbe = fwd(RtE);
         e_err = m_err;
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      model_eval();
      chk("StallF", 32'(StallF), 32'(e_sf));
      chk("StallD", 32'(StallD), 32'(e_sf));
      chk("StallE", 32'(StallE), 32'(e_se));
      chk("StallM", 32'(StallM), 32'(e_se));
      chk("FlushD", 32'(FlushD), 32'(e_fd));
      chk("FlushE", 32'(FlushE), 32'(e_fe));
      chk("FlushW", 32'(FlushW), 32'(e_fw));
      chk("ForwardAD", 32'(ForwardAD), 32'(e_fad));
      chk("ForwardBD", 32'(ForwardBD), 32'(e_fbd));
      chk("ForwardAE", 32'(ForwardAE), 32'(e_fae));
      chk("ForwardBE", 32'(ForwardBE), 32'(e_fbe));
      chk("mem_err", 32'(mem_err), 32'(e_err));
`ifdef HAZARD_STALL_CNT_EN
      chk("stall_count", stall_count, m_cnt);
`else
      chk("stall_count", stall_count, 32'd0);
`endif
   endtask

   // Check settled outputs, then advance one clock and update the model.
   task automatic tick();
      bit ms;
      #1;
      check_all();
      ms = e_se;
      @(posedge clk);
      if (!reset) begin
         if (!m_err) begin
            if (ms) begin
               m_pend = 1;
               m_waits++;
               if (m_waits == MAX_WAIT + 1) m_err = 1;
            end else begin
               m_pend = 0;
               m_waits = 0;
            end
         end
         if (e_sf) m_cnt++;
      end
      #1;
   endtask

   task automatic clear_in();
      RsD = 0; RtD = 0; RsE = 0; RtE = 0;
      WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
      MemtoRegE = 0; MemtoRegM = 0;
      BranchD = 0; PCSrcD = 0; dmem_req = 0; dmem_ready = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   initial begin
      clear_in();
      reset = 1;
      #1;
      check_all();
      chk("rst_FlushE", 32'(FlushE), 32'd1);
      tick();
      reset = 0;

      // Forwarding priority
      RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
      #1 chk("fwd_M", 32'(ForwardAE), 32'd2);
      tick();
      RegWriteM = 0;
      #1 chk("fwd_W", 32'(ForwardAE), 32'd1);
      tick();
      RsE = 0;
      #1 chk("fwd_zero", 32'(ForwardAE), 32'd0);
      tick();
      clear_in();

      // Load-use
      MemtoRegE = 1; RtE = 8; RsD = 8;
      #1 chk("lw_FlushE", 32'(FlushE), 32'd1);
      chk("lw_StallE", 32'(StallE), 32'd0);
      tick();
      MemtoRegE = 0;
      tick();
      // Load-use with taken branch: no FlushD
      MemtoRegE = 1; PCSrcD = 1;
      #1 chk("lw_br_FlushD", 32'(FlushD), 32'd0);
      tick();
      clear_in();

      // Branch hazard, then forward to comparator
      BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
      #1 chk("br_StallD", 32'(StallD), 32'd1);
      tick();
      RegWriteE = 0; WriteRegM = 3; RegWriteM = 1; PCSrcD = 1;
      #1 chk("br_ForwardAD", 32'(ForwardAD), 32'd1);
      chk("br_FlushD", 32'(FlushD), 32'd1);
      tick();
      clear_in();

      // 3-cycle memory wait
      begin
         int n = 0;
         dmem_req = 1; dmem_ready = 0;
         for (int i = 0; i < 3; i++) begin
            #1 if (StallM && FlushW && !FlushE) n++;
            tick();
         end
         dmem_ready = 1;
         #1 chk("mw_release", 32'(StallM), 32'd0);
         tick();
         chk("mw_cycles", 32'(n), 32'd3);
         dmem_req = 0;
         tick();
      end

      // Timeout
      do_reset();
      dmem_req = 1; dmem_ready = 0;
      for (int i = 0; i < MAX_WAIT + 1; i++) tick();
      #1 chk("to_err", 32'(mem_err), 32'd1);
      dmem_ready = 1;
      tick();
      tick();
      chk("to_sticky", 32'(mem_err), 32'd1);
      reset = 1;
      #1 chk("to_clear", 32'(mem_err), 32'd0);
      tick();
      reset = 0;
      clear_in();
      tick();

      // Counter: 5 load-use stalls + 3-cycle wait, then reset mid-wait
      do_reset();
      MemtoRegE = 1; RtE = 8; RsD = 8;
      for (int i = 0; i < 5; i++) tick();
      clear_in();
      dmem_req = 1;
      for (int i = 0; i < 3; i++) tick();
      dmem_ready = 1;
      tick();
      clear_in();
`ifdef HAZARD_STALL_CNT_EN
      #1 chk("cnt_8", stall_count, 32'd8);
`endif
      dmem_req = 1;
      tick();
      reset = 1;
      #1 chk("cnt_rst", stall_count, 32'd0);
      chk("rst_stallM", 32'(StallM), 32'd0);
      tick();
      reset = 0;
      clear_in();
      tick();

      // Random stimulus against the model
      for (int i = 0; i < 400; i++) begin
         RsD = 5'($urandom_range(0, 3));
         RtD = 5'($urandom_range(0, 3));
         RsE = 5'($urandom_range(0, 3));
         RtE = 5'($urandom_range(0, 3));
         WriteRegE = 5'($urandom_range(0, 3));
         WriteRegM = 5'($urandom_range(0, 3));
         WriteRegW = 5'($urandom_range(0, 3));
         RegWriteE = 1'($urandom);
         RegWriteM = 1'($urandom);
         RegWriteW = 1'($urandom);
         MemtoRegE = 1'($urandom);
         MemtoRegM = 1'($urandom);
         BranchD = 1'($urandom);
         PCSrcD = 1'($urandom);
         dmem_req = ($urandom_range(0, 9) < 3);
         dmem_ready = ($urandom_range(0, 9) < 6);
         reset = ($urandom_range(0, 59) == 0);
         tick();
      end
      reset = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end
endmodule
